// File: rtl/upd1771c_pkg.sv
// Shared types for the uPD1771C host-side packet sequencer: FSM states and FIFO entries.
package upd1771c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_HI = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_FLUSH   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } pkt_entry_t;

endpackage

// File: rtl/upd1771c_byte_fifo.sv
// Synchronous FIFO of packet entries; pointers carry an extra MSB for full/empty detection.
module upd1771c_byte_fifo
  import upd1771c_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  pkt_entry_t             push_data,
  input  logic                   pop,
  output pkt_entry_t             head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

  pkt_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/upd1771c_pkt_seq.sv
// Packet sequencer: buffers CPU command bytes and strobes them into the uPD1771C write port,
// pacing continuation bytes against the chip's DSB handshake.
module upd1771c_pkt_seq
  import upd1771c_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WR_CYCLES = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   CLK,
  input  logic                   RES,
  input  logic                   CKEN,
  input  logic [7:0]             S_DATA,
  input  logic                   S_FIRST,
  input  logic                   S_VALID,
  output logic                   S_READY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic [7:0]             DOUT,
  output logic                   NCS,
  output logic                   NWR,
  input  logic                   DSB,
  output logic                   BUSY,
  output logic                   ERR,
  input  logic                   ERR_CLR,
  output seq_state_t             DBG_STATE
);

  localparam int SW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t    state;
  pkt_entry_t    head;
  logic          full, empty, push, pop;
  logic          dsb_q1, dsb_s;
  logic          pkt_open, cur_first;
  logic [7:0]    cur_data;
  logic [SW-1:0] stb_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_hit, err_set;

  // Handshake: a byte is taken on any CLK edge where S_VALID && S_READY; S_READY is !full only,
  // never depends on S_VALID, and pushes ignore CKEN.
  assign push      = S_VALID && !full;
  assign S_READY   = !full;
  assign BUSY      = (state != ST_IDLE) || !empty;
  assign DBG_STATE = state;

  upd1771c_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RES),
    .push      (push),
    .push_data ({S_FIRST, S_DATA}),
    .pop       (pop),
    .head      (head),
    .level     (LEVEL),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      dsb_q1 <= 1'b0;
      dsb_s  <= 1'b0;
    end else begin
      dsb_q1 <= DSB;
      dsb_s  <= dsb_q1;
    end
  end

  always_comb begin
    pop     = 1'b0;
    err_set = 1'b0;
    to_hit  = (to_cnt == TW'(TIMEOUT - 1));
    if (CKEN && !empty) begin
      case (state)
        ST_IDLE:  pop = 1'b1;
        ST_FLUSH: pop = !head.first;
        default:  pop = 1'b0;
      endcase
    end
    // Orphan continuation byte, or the chip never answered within the timeout window.
    if (CKEN) begin
      if (state == ST_IDLE && !empty && !head.first && !pkt_open) err_set = 1'b1;
      if (state == ST_WAIT_HI && !dsb_s && to_hit)                err_set = 1'b1;
      if (state == ST_WAIT_LO && dsb_s && to_hit)                 err_set = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= ST_IDLE;
      pkt_open  <= 1'b0;
      cur_first <= 1'b0;
      cur_data  <= 8'h00;
      stb_cnt   <= '0;
      to_cnt    <= '0;
      DOUT      <= 8'h00;
      NCS       <= 1'b1;
      NWR       <= 1'b1;
      ERR       <= 1'b0;
    end else begin
      if (err_set)      ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;

      if (CKEN) begin
        case (state)
          ST_IDLE: begin
            if (!empty) begin
              cur_data  <= head.data;
              cur_first <= head.first;
              if (head.first) begin
                pkt_open <= 1'b1;
                state    <= ST_STROBE;
              end else if (pkt_open) begin
                to_cnt <= '0;
                state  <= ST_WAIT_HI;
              end
            end
          end
          ST_WAIT_HI: begin
            if (dsb_s) begin
              state <= ST_STROBE;
            end else if (to_hit) begin
              pkt_open <= 1'b0;
              state    <= ST_FLUSH;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
          ST_STROBE: begin
            // First cycle in STROBE only launches the strobe; DOUT is set together with NCS.
            if (NCS) begin
              NCS     <= 1'b0;
              NWR     <= 1'b0;
              DOUT    <= cur_data;
              stb_cnt <= '0;
            end else if (stb_cnt == SW'(WR_CYCLES - 1)) begin
              NCS   <= 1'b1;
              NWR   <= 1'b1;
              state <= ST_HOLD;
            end else begin
              stb_cnt <= stb_cnt + SW'(1);
            end
          end
          ST_HOLD: begin
            if (cur_first) begin
              state <= ST_IDLE;
            end else begin
              to_cnt <= '0;
              state  <= ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (!dsb_s) begin
              state <= ST_IDLE;
            end else if (to_hit) begin
              pkt_open <= 1'b0;
              state    <= ST_FLUSH;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
          ST_FLUSH: begin
            if (empty || head.first) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upd1771c_pkt_seq.sv
// Bench for upd1771c_pkt_seq: directed packets against a DSB model, strobes checked by a monitor
// that pops an expected-byte queue.
module tb_upd1771c_pkt_seq;
  import upd1771c_pkg::*;

  localparam int DEPTH     = 8;
  localparam int WR_CYCLES = 8;
  localparam int TIMEOUT   = 64;

  logic       CLK = 1'b0;
  logic       RES;
  logic       CKEN;
  logic [7:0] S_DATA;
  logic       S_FIRST;
  logic       S_VALID;
  logic       S_READY;
  logic [3:0] LEVEL;
  logic [7:0] DOUT;
  logic       NCS;
  logic       NWR;
  logic       DSB;
  logic       BUSY;
  logic       ERR;
  logic       ERR_CLR;
  seq_state_t DBG_STATE;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  int         exp_width    = WR_CYCLES;
  bit         strobe_abort = 1'b0;
  bit         cken_tog     = 1'b0;
  bit         dsb_auto     = 1'b0;
  logic       dsb_manual   = 1'b0;
  logic [7:0] fill [9];

  upd1771c_pkt_seq #(.DEPTH(DEPTH), .WR_CYCLES(WR_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .CKEN      (CKEN),
    .S_DATA    (S_DATA),
    .S_FIRST   (S_FIRST),
    .S_VALID   (S_VALID),
    .S_READY   (S_READY),
    .LEVEL     (LEVEL),
    .DOUT      (DOUT),
    .NCS       (NCS),
    .NWR       (NWR),
    .DSB       (DSB),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .ERR_CLR   (ERR_CLR),
    .DBG_STATE (DBG_STATE)
  );

  // clock / reset-independent drivers
  always #5 CLK = ~CLK;

  initial begin
    CKEN = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      CKEN = cken_tog ? ~CKEN : 1'b1;
    end
  end

  // DSB model: after each strobe ends, DSB falls 5 cycles later and rises 20 cycles later.
  initial begin
    int   fall_cnt;
    int   rise_cnt;
    logic ncs_prev;
    DSB = 1'b0;
    fall_cnt = 0;
    rise_cnt = 0;
    ncs_prev = 1'b1;
    forever begin
      @(posedge CLK);
      #2;
      if (!dsb_auto) begin
        DSB = dsb_manual;
        fall_cnt = 0;
        rise_cnt = 0;
      end else if (!ncs_prev && NCS) begin
        fall_cnt = 5;
        rise_cnt = 20;
      end else begin
        if (fall_cnt > 0) begin
          fall_cnt--;
          if (fall_cnt == 0) DSB = 1'b0;
        end
        if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) DSB = 1'b1;
        end
      end
      ncs_prev = NCS;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic       ncs_prev;
    int         width;
    logic [8:0] cur;
    ncs_prev = 1'b1;
    width = 0;
    cur = '0;
    forever begin
      @(negedge CLK);
      if (ncs_prev && !NCS) begin
        width = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: DOUT=0x%02h, no strobe was expected", DOUT);
        end else begin
          cur = exp_q.pop_front();
          check("strobe_dout", 32'(DOUT), 32'(cur[7:0]));
          check("strobe_nwr", 32'(NWR), 0);
          if (!cur[8]) check("cont_dsb_high", 32'(DSB), 1);
        end
      end else if (!NCS) begin
        width++;
      end else if (!ncs_prev) begin
        if (strobe_abort) begin
          strobe_abort = 1'b0;
        end else begin
          check("strobe_width", width, exp_width);
          check("hold_dout", 32'(DOUT), 32'(cur[7:0]));
          check("hold_nwr", 32'(NWR), 1);
        end
      end
      ncs_prev = NCS;
    end
  end

  // driver tasks (called aligned to a falling clock edge)
  task automatic push(input logic first, input logic [7:0] d, input bit exp_strobe);
    S_FIRST = first;
    S_DATA  = d;
    S_VALID = 1'b1;
    if (exp_strobe) exp_q.push_back({first, d});
    @(negedge CLK);
    S_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    S_VALID = 1'b0;
    ERR_CLR = 1'b0;
    repeat (10) @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    check("rst_ncs", 32'(NCS), 1);
    check("rst_nwr", 32'(NWR), 1);
    check("rst_dout", 32'(DOUT), 0);
    check("rst_ready", 32'(S_READY), 1);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_err", 32'(ERR), 0);
  endtask

  task automatic wait_ncs_low(input int max);
    for (int i = 0; i < max && NCS !== 1'b0; i++) @(negedge CLK);
    if (NCS !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ncs_low: NCS still high after %0d cycles, required low", max);
    end
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && BUSY !== 1'b0; i++) @(negedge CLK);
    if (BUSY !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: BUSY still high after %0d cycles, required low", max);
    end
  endtask

  task automatic wait_state(input seq_state_t st, input int max);
    for (int i = 0; i < max && DBG_STATE !== st; i++) @(negedge CLK);
    if (DBG_STATE !== st) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_state: state %0d after %0d cycles, required %0d", DBG_STATE, max, st);
    end
  endtask

  initial begin
    int t;
    RES = 1'b1;
    S_VALID = 1'b0;
    S_FIRST = 1'b0;
    S_DATA = 8'h00;
    ERR_CLR = 1'b0;
    fill = '{8'h80, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};

    // reset
    do_reset();
    check("rst_state", 32'(DBG_STATE), 32'(ST_IDLE));

    // normal packet with push-to-strobe latency
    dsb_auto = 1'b1;
    push(1'b1, 8'h02, 1'b1);
    check("lat_level_n", 32'(LEVEL), 1);
    check("lat_ncs_n", 32'(NCS), 1);
    @(negedge CLK);
    check("lat_level_n1", 32'(LEVEL), 0);
    check("lat_ncs_n1", 32'(NCS), 1);
    @(negedge CLK);
    check("lat_ncs_n2", 32'(NCS), 0);
    push(1'b0, 8'h80, 1'b1);
    push(1'b0, 8'h35, 1'b1);
    push(1'b0, 8'h15, 1'b1);
    wait_idle(600);
    check("pkt_err", 32'(ERR), 0);
    check("pkt_level", 32'(LEVEL), 0);
    dsb_auto = 1'b0;
    repeat (3) @(negedge CLK);

    // FIFO full while DSB held low, then drain
    push(1'b1, 8'h02, 1'b1);
    wait_ncs_low(20);
    for (int i = 0; i < 8; i++) push(1'b0, fill[i], 1'b1);
    check("full_level", 32'(LEVEL), 8);
    check("full_ready", 32'(S_READY), 0);
    push(1'b0, fill[8], 1'b0);
    check("full_level_hold", 32'(LEVEL), 8);
    dsb_manual = 1'b1;
    repeat (2) @(negedge CLK);
    dsb_auto = 1'b1;
    dsb_manual = 1'b0;
    wait_idle(2000);
    check("drain_level", 32'(LEVEL), 0);
    check("drain_err", 32'(ERR), 0);
    dsb_auto = 1'b0;
    repeat (3) @(negedge CLK);

    // timeout and flush
    push(1'b1, 8'h02, 1'b1);
    push(1'b0, 8'h80, 1'b0);
    push(1'b0, 8'h4F, 1'b0);
    push(1'b0, 8'h15, 1'b0);
    wait_state(ST_WAIT_HI, 100);
    t = 0;
    while (ERR !== 1'b1 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    check("timeout_cycles", t, TIMEOUT);
    wait_idle(20);
    check("flush_level", 32'(LEVEL), 0);
    check("flush_err", 32'(ERR), 1);
    push(1'b1, 8'h02, 1'b1);
    wait_idle(50);
    check("err_sticky", 32'(ERR), 1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    check("err_clr", 32'(ERR), 0);

    // orphan byte
    do_reset();
    push(1'b0, 8'h35, 1'b0);
    repeat (3) @(negedge CLK);
    check("orphan_err", 32'(ERR), 1);
    check("orphan_level", 32'(LEVEL), 0);
    check("orphan_busy", 32'(BUSY), 0);

    // CKEN stall stretches the strobe; reset mid-strobe
    do_reset();
    cken_tog = 1'b1;
    exp_width = 2 * WR_CYCLES;
    push(1'b1, 8'h02, 1'b1);
    wait_ncs_low(20);
    wait_idle(60);
    strobe_abort = 1'b1;
    push(1'b1, 8'h5A, 1'b1);
    push(1'b0, 8'h80, 1'b0);
    push(1'b0, 8'h35, 1'b0);
    wait_ncs_low(20);
    repeat (3) @(negedge CLK);
    check("mid_level", 32'(LEVEL), 2);
    #1;
    RES = 1'b1;
    #1;
    check("abort_ncs", 32'(NCS), 1);
    check("abort_nwr", 32'(NWR), 1);
    check("abort_level", 32'(LEVEL), 0);
    check("abort_ready", 32'(S_READY), 1);
    @(negedge CLK);
    RES = 1'b0;
    cken_tog = 1'b0;
    repeat (5) @(negedge CLK);
    check("abort_idle_ncs", 32'(NCS), 1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/upd1771c_pkt_seq.md
# upd1771c_pkt_seq

Host-side packet sequencer for the uPD1771C sound core. It buffers command bytes from the system CPU bus in a small FIFO. It drives the chip's parallel write port (PA data, PB7 nCS, PB6 nWR) and paces each byte of a packet against the chip's DSB handshake on PB0. Bytes are paced so the CPU never has to poll DSB. It sits between the SCV CPU I/O decode and the `upd1771c` instance.

## Interface
- `DEPTH`, default 8: FIFO entries; power of 2, at least 2.
- `WR_CYCLES`, default 8: strobe width, in CKEN-qualified cycles.
- `TIMEOUT`, default 4096: maximum DSB wait, in CKEN-qualified cycles, before abort.
- `CLK`, in, 1: core clock, rising edge.
- `RES`, in, 1: asynchronous reset, active-high.
- `CKEN`, in, 1: clock enable; the sequencer FSM and counters advance only when CKEN=1.
- `S_DATA`, in, 8: command byte.
- `S_FIRST`, in, 1: byte is the first of a packet.
- `S_VALID`, in, 1: push request.
- `S_READY`, out, 1: FIFO not full.
- `LEVEL`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `DOUT`, out, 8: to chip PA_I.
- `NCS`, out, 1: to chip PB_I[7].
- `NWR`, out, 1: to chip PB_I[6].
- `DSB`, in, 1: from chip PB_O[0].
- `BUSY`, out, 1: FSM not in IDLE, or FIFO not empty.
- `ERR`, out, 1: sticky error flag.
- `ERR_CLR`, in, 1: clears ERR.

## Operation
- **Push.** A push occurs on any CLK edge with S_VALID & S_READY, independent of CKEN. The entry stored is {S_FIRST, S_DATA}. S_READY is derived from full only, so there is no push-when-full bypass.
- **DSB input.** DSB passes through a 2-flop synchronizer, reset value 0. The FSM sees the synchronized value, `dsb_s`.
- **IDLE.** When the FIFO is non-empty, the FSM pops the head.
  - If FIRST=1, go to STROBE and set `pkt_open`.
  - If FIRST=0 and `pkt_open`=1, go to WAIT_HI.
  - If FIRST=0 and `pkt_open`=0 (orphan byte), drop it, set ERR and stay in IDLE.
- **WAIT_HI.** Wait for `dsb_s`=1, then go to STROBE. The timeout counter runs.
- **STROBE.** Drive DOUT with the popped byte; NCS=NWR=0 for exactly WR_CYCLES CKEN cycles.
  - Then NCS=NWR=1 and go to HOLD.
  - A first byte then returns to IDLE.
  - A continuation byte goes to WAIT_LO.
- **HOLD.** Lasts one CKEN cycle. DOUT is unchanged.
- **WAIT_LO.** Wait for `dsb_s`=0, then go to IDLE. The timeout counter runs.
- **Timeout.** If the counter reaches TIMEOUT in WAIT_HI or WAIT_LO:
  - set ERR and clear `pkt_open`;
  - go to FLUSH, discarding the current byte.
- **FLUSH.** Pop and discard entries with FIRST=0, one per CKEN cycle. Go to IDLE when the FIFO is empty or the head has FIRST=1; that head is not popped.
- **ERR_CLR.** Clears ERR. If an error set and ERR_CLR occur in the same cycle, the set wins.

## Timing
- **Reset values.** NCS=1, NWR=1, DOUT=0x00, S_READY=1, LEVEL=0, BUSY=0, ERR=0. State is IDLE, `pkt_open`=0 and the FIFO is empty.
- **Reset mid-operation.** Asserting RES during a strobe raises NCS/NWR immediately (asynchronous) and empties the FIFO.
- **Push to strobe latency.** With CKEN held at 1 and the FSM idle, a first byte pushed at edge N:
  - is visible at edge N+1;
  - has NCS low after edge N+2.
- **DSB latency.** DSB edge to FSM reaction is 2 CLK edges from the synchronizer, plus one CKEN cycle.
- **DOUT setup and hold.** DOUT is valid from the cycle NCS falls through one CKEN cycle after NCS rises.
- **CKEN=0.** The FSM, strobe counter and timeout counter freeze; the strobe stretches in CLK time. Push and LEVEL continue to update.
- **Counter reset.** The timeout counter clears on entry to WAIT_HI or WAIT_LO. Its width is $clog2(TIMEOUT+1).
- **Simultaneous events.**
  - Push and pop in the same cycle leave LEVEL unchanged.
  - Push when the FIFO is empty, with a pop in that cycle, is not possible; the pop sees the entry one cycle later.
- **Pointer wrap.** FIFO pointers wrap modulo DEPTH. Full/empty detection uses an extra MSB.

## Structure
- **Package `upd1771c_pkg`** holds:
  - the FSM state enum (IDLE, WAIT_HI, STROBE, HOLD, WAIT_LO, FLUSH);
  - the `pkt_entry_t` struct, {first, data[7:0]}.
- **Sub-module `upd1771c_byte_fifo`** is a synchronous FIFO with parameter DEPTH. It has push, pop, head and level, and async clear on RES.
- The synchronizer, FSM and counters live in `upd1771c_pkt_seq`.

## Test plan
1. **Reset.** Hold RES for 10 cycles, then release. All outputs must hold their reset values, and DOUT=0x00.
2. **Normal packet.** Push packet 02(FIRST),80,35,15 against a DSB model (DSB rises 20 cycles after each strobe ends and falls 5 cycles after the next strobe).
   - 0x02 strobes without waiting for DSB.
   - Each continuation waits for DSB high, then low.
   - NCS/NWR are low for exactly 8 cycles each, and DOUT matches at every NCS falling edge.
3. **FIFO full.** Hold DSB low. Push 02 then 80 plus 8 further bytes.
   - After the 02 strobe, LEVEL reaches 8 and S_READY=0.
   - The 10th push is not accepted.
   - Releasing DSB drains the FIFO in order.
4. **Timeout.** With TIMEOUT=64, push 02,80,4F,15 and hold DSB at 0.
   - ERR rises 64 CKEN cycles after entry to WAIT_HI.
   - 4F and 15 are flushed with no strobe.
   - A following 02(FIRST) strobes normally.
   - ERR_CLR then clears ERR.
5. **Orphan byte.** Push 35 with FIRST=0 after reset. The byte is dropped with no strobe, and ERR=1.
6. **CKEN stall and reset.** With CKEN toggling 1/0, a strobe lasts 16 CLK cycles. Asserting RES at strobe cycle 4 gives NCS=1 within the same cycle, and LEVEL=0.
